// File: rtl/axis_switch_rr_n_if.sv
// AXI4-Stream N:1 switch bundle: slave streams, suppress mask,
// master stream and status, with switch-side and driver-side views.
interface axis_switch_rr_n_if #(
  parameter int NUM_IN  = 4,
  parameter int TDATA_L = 512,
  parameter int TUSER_L = 81,
  parameter int TKEEP_L = 16
);
  logic [NUM_IN-1:0]         s_req_supress;
  logic [NUM_IN*TDATA_L-1:0] axi_s_tdata_i;
  logic [NUM_IN*TUSER_L-1:0] axi_s_tuser_i;
  logic [NUM_IN*TKEEP_L-1:0] axi_s_tkeep_i;
  logic [NUM_IN-1:0]         axi_s_tlast_i;
  logic [NUM_IN-1:0]         axi_s_tvalid_i;
  logic [NUM_IN-1:0]         axi_s_tready_o;
  logic [TDATA_L-1:0]        axi_m0_tdata_o;
  logic [TUSER_L-1:0]        axi_m0_tuser_o;
  logic [TKEEP_L-1:0]        axi_m0_tkeep_o;
  logic                      axi_m0_tlast_o;
  logic                      axi_m0_tvalid_o;
  logic                      axi_m0_tready_i;
  logic [NUM_IN-1:0]         grant_o;
  logic [31:0]               pkt_cnt_o;

  modport slave (
    input  s_req_supress,
    input  axi_s_tdata_i,
    input  axi_s_tuser_i,
    input  axi_s_tkeep_i,
    input  axi_s_tlast_i,
    input  axi_s_tvalid_i,
    output axi_s_tready_o,
    output axi_m0_tdata_o,
    output axi_m0_tuser_o,
    output axi_m0_tkeep_o,
    output axi_m0_tlast_o,
    output axi_m0_tvalid_o,
    input  axi_m0_tready_i,
    output grant_o,
    output pkt_cnt_o
  );

  modport master (
    output s_req_supress,
    output axi_s_tdata_i,
    output axi_s_tuser_i,
    output axi_s_tkeep_i,
    output axi_s_tlast_i,
    output axi_s_tvalid_i,
    input  axi_s_tready_o,
    input  axi_m0_tdata_o,
    input  axi_m0_tuser_o,
    input  axi_m0_tkeep_o,
    input  axi_m0_tlast_o,
    input  axi_m0_tvalid_o,
    output axi_m0_tready_i,
    input  grant_o,
    input  pkt_cnt_o
  );
endinterface

// File: rtl/axis_switch_rr_n.sv
// Packet-granular round-robin AXI4-Stream N:1 switch
// with a 2-entry skid buffer on the master side.
module axis_switch_rr_n #(
  parameter int NUM_IN  = 4,
  parameter int TDATA_L = 512,
  parameter int TUSER_L = 81,
  parameter int TKEEP_L = 16
) (
  input logic               clk,
  input logic               rst_n,
  axis_switch_rr_n_if.slave bus
);
  localparam int IW = $clog2(NUM_IN);
  localparam int BW = TDATA_L + TUSER_L + TKEEP_L + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state;
  logic [NUM_IN-1:0] grant;
  logic [IW-1:0]     gidx;
  logic [IW-1:0]     last_grant;
  logic [NUM_IN-1:0] elig;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     pick;
  logic              pick_v;
  logic [BW-1:0]     in_beat;
  logic [BW-1:0]     out_q;
  logic [BW-1:0]     skid_q;
  logic              out_v;
  logic              skid_v;
  logic              full;
  logic              push;
  logic              pop;
  logic [31:0]       pkt_cnt;

  assign elig = bus.axi_s_tvalid_i & ~bus.s_req_supress;

  // Scan upward starting one past the previous owner.
  always_comb begin
    cand   = '0;
    pick   = '0;
    pick_v = 1'b0;
    for (int i = 1; i <= NUM_IN; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_IN);
      if (!pick_v && elig[cand]) begin
        pick_v = 1'b1;
        pick   = cand;
      end
    end
  end

  assign in_beat = {
    bus.axi_s_tdata_i[int'(gidx)*TDATA_L +: TDATA_L],
    bus.axi_s_tuser_i[int'(gidx)*TUSER_L +: TUSER_L],
    bus.axi_s_tkeep_i[int'(gidx)*TKEEP_L +: TKEEP_L],
    bus.axi_s_tlast_i[gidx]
  };

  assign full = out_v & skid_v;
  assign push = (state == XFER) & ~full
              & bus.axi_s_tvalid_i[gidx];
  assign pop  = out_v & bus.axi_m0_tready_i;

  assign bus.axi_s_tready_o =
    (rst_n && state == XFER && !full) ? grant : '0;

  assign {bus.axi_m0_tdata_o,
          bus.axi_m0_tuser_o,
          bus.axi_m0_tkeep_o,
          bus.axi_m0_tlast_o} = out_q;
  assign bus.axi_m0_tvalid_o = out_v;
  assign bus.grant_o         = grant;
  assign bus.pkt_cnt_o       = pkt_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IW'(NUM_IN - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_v) begin
            state <= XFER;
            gidx  <= pick;
            grant <= NUM_IN'(1) << pick;
          end
        end
        XFER: begin
          if (push && in_beat[0]) begin
            state      <= IDLE;
            last_grant <= gidx;
            grant      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The skid entry only fills while the head is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end else if (push) begin
        out_q <= in_beat;
      end else begin
        out_v <= 1'b0;
      end
    end else if (push) begin
      if (!out_v) begin
        out_q <= in_beat;
        out_v <= 1'b1;
      end else begin
        skid_q <= in_beat;
        skid_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (pop && out_q[0]) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_axis_switch_rr_n.sv
// Bench for axis_switch_rr_n: random packets checked per cycle
// against a queue-based round-robin packet model.
module tb_axis_switch_rr_n;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int UW = 8;
  localparam int KW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_switch_rr_n_if #(
    .NUM_IN(N), .TDATA_L(DW),
    .TUSER_L(UW), .TKEEP_L(KW)
  ) bus ();

  axis_switch_rr_n #(
    .NUM_IN(N), .TDATA_L(DW),
    .TUSER_L(UW), .TKEEP_L(KW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  beat_t       src[N][$];
  beat_t       exp_q[$];
  logic [N-1:0] en = '1;
  logic [N-1:0] mask = '0;
  logic         m_rdy = 1'b1;
  logic [N-1:0] elig;
  bit           m_xfer = 0;
  int           owner = 0;
  int           last = N - 1;
  logic [31:0]  m_cnt = '0;
  bit           s_hs, m_hs;
  int           cyc = 0;
  logic [N-1:0] prev_g = '0;
  int           g_log[$];
  int           g_cyc[$];
  bit           full_seen = 0;
  int           dut_beats = 0;
  int           dut_lasts = 0;
  int           last_pos = 0;
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic load(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = DW'($urandom);
      b.u = UW'($urandom);
      b.k = KW'($urandom);
      b.l = (i == len - 1);
      src[p].push_back(b);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b = (src[k].size() > 0) ? src[k][0] : '0;
      bus.axi_s_tvalid_i[k] = en[k] && src[k].size() > 0;
      bus.axi_s_tdata_i[k*DW +: DW] = b.d;
      bus.axi_s_tuser_i[k*UW +: UW] = b.u;
      bus.axi_s_tkeep_i[k*KW +: KW] = b.k;
      bus.axi_s_tlast_i[k] = b.l;
    end
    bus.s_req_supress   = mask;
    bus.axi_m0_tready_i = m_rdy;
  endtask

  // Expected outputs: owner set by the model, buffer = accepted-not-sent.
  task automatic check();
    logic [N-1:0] eg, et;
    eg = m_xfer ? (N'(1) << owner) : '0;
    et = (rst_n && m_xfer && exp_q.size() < 2) ? eg : '0;
    chk("grant", 64'(bus.grant_o), 64'(eg));
    chk("tready", 64'(bus.axi_s_tready_o), 64'(et));
    chk("m_tvalid", 64'(bus.axi_m0_tvalid_o),
        64'(exp_q.size() > 0));
    if (exp_q.size() > 0)
      chk("m_beat",
          64'({bus.axi_m0_tdata_o, bus.axi_m0_tuser_o,
               bus.axi_m0_tkeep_o, bus.axi_m0_tlast_o}),
          64'(exp_q[0]));
    chk("pkt_cnt", 64'(bus.pkt_cnt_o), 64'(m_cnt));
    if (bus.grant_o[1] && !bus.axi_s_tready_o[1])
      full_seen = 1;
    if (bus.axi_m0_tvalid_o && m_rdy) begin
      dut_beats++;
      if (bus.axi_m0_tlast_o) begin
        dut_lasts++;
        last_pos = dut_beats;
      end
    end
    for (int k = 0; k < N; k++)
      elig[k] = en[k] && src[k].size() > 0 && !mask[k];
    s_hs = rst_n && m_xfer && exp_q.size() < 2
        && en[owner] && src[owner].size() > 0;
    m_hs = exp_q.size() > 0 && m_rdy;
  endtask

  task automatic commit();
    beat_t b;
    if (!rst_n) begin
      m_xfer = 0;
      last   = N - 1;
      m_cnt  = '0;
      exp_q.delete();
      for (int k = 0; k < N; k++) src[k].delete();
    end else begin
      if (m_hs) begin
        if (exp_q[0].l) m_cnt = m_cnt + 32'd1;
        void'(exp_q.pop_front());
      end
      if (m_xfer) begin
        if (s_hs) begin
          b = src[owner].pop_front();
          exp_q.push_back(b);
          if (b.l) begin
            m_xfer = 0;
            last   = owner;
          end
        end
      end else begin
        for (int i = 1; i <= N; i++) begin
          if (elig[(last + i) % N]) begin
            m_xfer = 1;
            owner  = (last + i) % N;
            break;
          end
        end
      end
    end
    if (bus.grant_o != '0 && prev_g == '0) begin
      for (int k = 0; k < N; k++)
        if (bus.grant_o[k]) g_log.push_back(k);
      g_cyc.push_back(cyc);
    end
    prev_g = bus.grant_o;
    cyc++;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bit busy = 1;
    while (busy && n < budget) begin
      cycle();
      n++;
      busy = m_xfer || exp_q.size() > 0;
      for (int k = 0; k < N; k++)
        if (src[k].size() > 0) busy = 1;
    end
    chk("drain_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    chk("rst_data", 64'(bus.axi_m0_tdata_o), 64'd0);
    chk("rst_user", 64'(bus.axi_m0_tuser_o), 64'd0);
    chk("rst_keep", 64'(bus.axi_m0_tkeep_o), 64'd0);
    chk("rst_last", 64'(bus.axi_m0_tlast_o), 64'd0);
    chk("rst_grant", 64'(bus.grant_o), 64'd0);
  endtask

  initial begin
    int n;
    do_reset();

    // Four ports always requesting, 3-beat packets.
    for (int k = 0; k < N; k++) begin
      load(k, 3);
      load(k, 3);
    end
    g_log.delete();
    n = 0;
    while (m_cnt != 32'd5 && n < 200) begin
      cycle();
      n++;
    end
    chk("rr_cnt5", 64'(bus.pkt_cnt_o), 64'd5);
    chk("rr_g0", 64'(g_log[0]), 64'd0);
    chk("rr_g1", 64'(g_log[1]), 64'd1);
    chk("rr_g2", 64'(g_log[2]), 64'd2);
    chk("rr_g3", 64'(g_log[3]), 64'd3);
    chk("rr_g4", 64'(g_log[4]), 64'd0);
    drain(300);

    // Suppressed requester never wins until unmasked.
    do_reset();
    mask = 4'b0100;
    load(2, 2);
    for (int i = 0; i < 20; i++) cycle();
    chk("supp_grant", 64'(bus.grant_o), 64'd0);
    mask = '0;
    cycle();
    chk("unsupp_grant", 64'(bus.grant_o), 64'b0100);
    drain(50);

    // Backpressure fills the skid buffer.
    do_reset();
    load(1, 8);
    full_seen = 0;
    dut_beats = 0;
    dut_lasts = 0;
    n = 0;
    while ((m_xfer || exp_q.size() > 0 ||
            src[1].size() > 0) && n < 100) begin
      m_rdy = (n % 3 == 0);
      cycle();
      n++;
    end
    m_rdy = 1'b1;
    chk("bp_full_seen", 64'(full_seen), 64'd1);
    chk("bp_beats", 64'(dut_beats), 64'd8);
    chk("bp_lasts", 64'(dut_lasts), 64'd1);
    chk("bp_last_pos", 64'(last_pos), 64'd8);

    // Reset in the middle of a 4-beat packet.
    load(1, 4);
    n = 0;
    while (src[1].size() > 3 && n < 20) begin
      cycle();
      n++;
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_tvalid", 64'(bus.axi_m0_tvalid_o), 64'd0);
    chk("mid_rst_grant", 64'(bus.grant_o), 64'd0);
    chk("mid_rst_cnt", 64'(bus.pkt_cnt_o), 64'd0);
    load(2, 2);
    load(0, 2);
    g_log.delete();
    drain(50);
    chk("post_rst_first", 64'(g_log[0]), 64'd0);

    // Single-beat packets from ports 0 and 3.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load(0, 1);
      load(3, 1);
    end
    g_log.delete();
    g_cyc.delete();
    drain(50);
    chk("sb_g0", 64'(g_log[0]), 64'd0);
    chk("sb_g1", 64'(g_log[1]), 64'd3);
    chk("sb_g2", 64'(g_log[2]), 64'd0);
    chk("sb_gap1", 64'(g_cyc[1] - g_cyc[0]), 64'd2);
    chk("sb_gap2", 64'(g_cyc[2] - g_cyc[1]), 64'd2);

    // Packet counter wraps.
    force dut.pkt_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt;
    m_cnt = 32'hFFFF_FFFF;
    load(2, 1);
    drain(20);
    chk("cnt_wrap", 64'(bus.pkt_cnt_o), 64'd0);

    // Random traffic, masks and backpressure.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, N - 1);
        if (src[n].size() < 8) load(n, $urandom_range(1, 4));
      end
      en    = N'($urandom) | N'($urandom);
      mask  = N'($urandom) & N'($urandom) & N'($urandom);
      m_rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    en    = '1;
    mask  = '0;
    m_rdy = 1'b1;
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/axis_switch_rr_n.md
AXIS_SWITCH_RR_N -- requirements
Module: axis_switch_rr_n

Interface
REQ-001 Parameter NUM_IN, default 4: number of AXI4-Stream slave inputs; legal range 2..16.
REQ-002 Parameter TDATA_L, default 512: TDATA width per port.
REQ-003 Parameter TUSER_L, default 81: TUSER width per port.
REQ-004 Parameter TKEEP_L, default 16: TKEEP width per port.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 s_req_supress  in  NUM_IN  per-port mask; 1 blocks new grants to that port.
REQ-009 axi_s_tdata_i  in  NUM_IN*TDATA_L  flattened slave TDATA; port k at bits [k*TDATA_L +: TDATA_L].
REQ-010 axi_s_tuser_i  in  NUM_IN*TUSER_L  flattened slave TUSER.
REQ-011 axi_s_tkeep_i  in  NUM_IN*TKEEP_L  flattened slave TKEEP.
REQ-012 axi_s_tlast_i / axi_s_tvalid_i  in  NUM_IN each  per-port TLAST and TVALID.
REQ-013 axi_s_tready_o  out  NUM_IN  per-port TREADY.
REQ-014 axi_m0_tdata_o / axi_m0_tuser_o / axi_m0_tkeep_o / axi_m0_tlast_o / axi_m0_tvalid_o  out  TDATA_L / TUSER_L / TKEEP_L / 1 / 1  master stream, driven from registers.
REQ-015 axi_m0_tready_i  in  1  master TREADY.
REQ-016 grant_o  out  NUM_IN  one-hot current owner; all-zero when idle.
REQ-017 pkt_cnt_o  out  32  count of packets completed on the master side; wraps from 2^32-1 to 0.

Function
REQ-018 FSM states: IDLE and XFER.
REQ-019 In IDLE, eligible ports SHALL be those with tvalid=1 and s_req_supress=0.
REQ-020 In IDLE, the block SHALL grant the first eligible port found searching upward from (last_grant+1) mod NUM_IN.
REQ-021 The grant SHALL be registered, setting grant_o and entering XFER on the next edge; no slave tready is asserted in IDLE.
REQ-022 In XFER, only the granted port's tready MAY be 1; it SHALL equal the buffer's not-full flag.
REQ-023 Asserting s_req_supress mid-packet SHALL NOT abort or pause the granted packet.
REQ-024 When a beat with tlast=1 is accepted from the granted port, the FSM SHALL update last_grant to that port and return to IDLE.
  - The minimum gap between packets is one idle cycle.
  - Single-beat packets follow the same path.
REQ-025 The output SHALL be a 2-entry skid buffer.
  - Beats are forwarded in order, without loss or duplication, with TDATA/TUSER/TKEEP/TLAST unchanged.
  - Latency from slave accept to axi_m0_tvalid_o is 1 cycle.
REQ-026 Sustained throughput in XFER SHALL be one beat per cycle while axi_m0_tready_i=1.
REQ-027 Buffer full (2 entries) SHALL force the granted tready to 0.
REQ-028 Simultaneous master pop and slave push with the buffer full is not a push, because tready is 0 in that cycle.
REQ-029 axi_m0_* outputs SHALL hold stable while axi_m0_tvalid_o=1 and axi_m0_tready_i=0.
REQ-030 pkt_cnt_o SHALL increment by 1 on each master handshake with axi_m0_tlast_o=1.
REQ-031 If all ports are suppressed or not valid, the FSM SHALL remain in IDLE with grant_o=0.

Reset
REQ-032 On rst_n=0 at a clk edge, the block SHALL reset to:
  - state IDLE; grant_o=0; last_grant=NUM_IN-1, so port 0 has first priority.
  - buffer empty; axi_m0_tvalid_o=0; axi_m0_tlast_o=0; axi_m0_tdata/tuser/tkeep=0.
  - pkt_cnt_o=0.
REQ-033 Reset asserted mid-packet SHALL discard buffered beats and abandon the packet; no partial-packet recovery is performed.
REQ-034 All axi_s_tready_o SHALL be 0 while rst_n=0.

Verification
REQ-035 NUM_IN=4, all ports valid continuously, 3-beat packets, tready=1 -> grant order 0,1,2,3,0; pkt_cnt_o=5 after 5 packets; beat data intact.
REQ-036 Port 2 only valid, s_req_supress=4'b0100 -> grant_o stays 0 for 20 cycles; clearing the mask -> grant_o=4'b0100 one cycle later.
REQ-037 Port 1 streams 8 beats while axi_m0_tready_i toggles 1,0,0,1... -> granted tready drops once 2 entries are held; all 8 beats appear in order; tlast on beat 8 only.
REQ-038 Port 0 single-beat packets back-to-back with port 3 valid -> grants alternate 0,3,0; exactly one idle cycle between packets.
REQ-039 rst_n pulsed low during beat 2 of a 4-beat packet -> axi_m0_tvalid_o=0 and grant_o=0 the next cycle; pkt_cnt_o=0; next grant goes to port 0.
REQ-040 pkt_cnt_o preloaded via force to 32'hFFFFFFFF, one packet completes -> pkt_cnt_o=0.
